dac_wave_sequencer: RTL and testbench

Multi-channel waveform sequencer for the MAX5134 quad DAC. It generalises the single-channel sawtooth ramp generator to N phase-accumulator channels, each with its own step and waveform mode. On each sample tick it streams one 24-bit write frame per enabled channel to the DAC SPI sender, using a send/busy handshake. It sits between the control logic and the DAC SPI block, and flags overrun and handshake faults.

---
 rtl/dac_wave_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_dac_wave_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_sequencer.sv
// Multi-channel phase-accumulator waveform sequencer for the MAX5134 quad DAC.
// On each sample tick, one 24-bit frame per enabled channel goes to the SPI sender.
`timescale 1ns/1ps
module dac_wave_sequencer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ACC_WIDTH    = 16,
  parameter int unsigned INTERVAL     = 3624,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic                              fpga_clock,
  input  logic                              rst,
  input  logic [NUM_CHANNELS-1:0]           channel_en,
  input  logic [ACC_WIDTH*NUM_CHANNELS-1:0] step,
  input  logic [2*NUM_CHANNELS-1:0]         mode,
  input  logic                              clear_status,
  input  logic                              spi_busy,
  output logic                              send,
  output logic [23:0]                       dac_data,
  output logic                              frame_active,
  output logic                              overrun,
  output logic                              fault
);

  localparam int unsigned CntW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWaitAck, StWaitDone} state_e;

  state_e               r_state;
  logic [1:0]           r_ch_idx;
  logic [CntW-1:0]      r_cnt;
  logic [AckW-1:0]      r_ack_cnt;
  logic                 r_send;
  logic [23:0]          r_dac_data;
  logic                 r_frame_active;
  logic                 r_overrun;
  logic                 r_fault;
  logic [ACC_WIDTH-1:0] r_acc [NUM_CHANNELS];

  logic                 w_tick;
  logic                 w_first_vld, w_next_vld;
  logic [1:0]           w_first_idx, w_next_idx;
  logic [ACC_WIDTH-1:0] w_acc_sel, w_step_sel, w_sample;
  logic [1:0]           w_mode_sel;
  logic [15:0]          w_field;

  assign w_tick = (r_cnt == CntW'(INTERVAL - 1));

  always_ff @(posedge fpga_clock or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Lowest enabled channel, and lowest enabled channel above the current one.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = 2'd0;
    w_next_vld  = 1'b0;
    w_next_idx  = 2'd0;
    for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (channel_en[i]) begin
        w_first_vld = 1'b1;
        w_first_idx = 2'(i);
      end
      if (channel_en[i] && (2'(i) > r_ch_idx)) begin
        w_next_vld = 1'b1;
        w_next_idx = 2'(i);
      end
    end
  end

  always_comb begin
    w_acc_sel  = '0;
    w_step_sel = '0;
    w_mode_sel = 2'b00;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (r_ch_idx == 2'(i)) begin
        w_acc_sel  = r_acc[i];
        w_step_sel = step[i*ACC_WIDTH +: ACC_WIDTH];
        w_mode_sel = mode[i*2 +: 2];
      end
    end
  end

  always_comb begin
    case (w_mode_sel)
      2'b00:   w_sample = w_acc_sel;
      2'b01:   w_sample = w_acc_sel[ACC_WIDTH-1] ? ~{w_acc_sel[ACC_WIDTH-2:0], 1'b0}
                                                 :  {w_acc_sel[ACC_WIDTH-2:0], 1'b0};
      2'b10:   w_sample = {ACC_WIDTH{w_acc_sel[ACC_WIDTH-1]}};
      default: w_sample = w_step_sel;
    endcase
  end

  // Sample is MSB-aligned into the DAC's 16-bit data field.
  if (ACC_WIDTH >= 16) begin : g_field_wide
    assign w_field = w_sample[ACC_WIDTH-1 -: 16];
  end else begin : g_field_narrow
    assign w_field = {w_sample, (16 - ACC_WIDTH)'(0)};
  end

  always_ff @(posedge fpga_clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        r_acc[i] <= '0;
      end
    end else if (r_state == StLoad) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        if (r_ch_idx == 2'(i)) begin
          r_acc[i] <= r_acc[i] + w_step_sel;
        end
      end
    end
  end

  always_ff @(posedge fpga_clock or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_ch_idx       <= 2'd0;
      r_ack_cnt      <= '0;
      r_send         <= 1'b0;
      r_dac_data     <= 24'd0;
      r_frame_active <= 1'b0;
      r_overrun      <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_send <= 1'b0;
      if (clear_status) begin
        r_overrun <= 1'b0;
        r_fault   <= 1'b0;
      end
      // Ticks during a sequence are dropped, never queued.
      if (w_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_tick && w_first_vld) begin
            r_ch_idx       <= w_first_idx;
            r_state        <= StLoad;
            r_frame_active <= 1'b1;
          end
        end
        StLoad: begin
          r_dac_data <= {4'b0011, 4'b0001 << r_ch_idx, w_field};
          r_send     <= 1'b1;
          r_ack_cnt  <= '0;
          r_state    <= StWaitAck;
        end
        StWaitAck: begin
          if (spi_busy) begin
            r_state <= StWaitDone;
          end else if (r_ack_cnt == AckW'(ACK_TIMEOUT - 1)) begin
            r_fault        <= 1'b1;
            r_state        <= StIdle;
            r_frame_active <= 1'b0;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        StWaitDone: begin
          if (!spi_busy) begin
            if (w_next_vld) begin
              r_ch_idx <= w_next_idx;
              r_state  <= StLoad;
            end else begin
              r_state        <= StIdle;
              r_frame_active <= 1'b0;
            end
          end
        end
        default: begin
          r_state        <= StIdle;
          r_frame_active <= 1'b0;
        end
      endcase
    end
  end

  assign send         = r_send;
  assign dac_data     = r_dac_data;
  assign frame_active = r_frame_active;
  assign overrun      = r_overrun;
  assign fault        = r_fault;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Bench for dac_wave_sequencer: scoreboard of expected frames checked on each send pulse,
// plus directed checks of overrun, ack timeout and asynchronous reset.
`timescale 1ns/1ps
module tb_dac_wave_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned IV  = 32;
  localparam int unsigned AT  = 16;

  logic        fpga_clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  channel_en = 4'b0000;
  logic [63:0] step = 64'd0;
  logic [7:0]  mode = 8'd0;
  logic        clear_status = 1'b0;
  logic        spi_busy = 1'b0;
  logic        send;
  logic [23:0] dac_data;
  logic        frame_active;
  logic        overrun;
  logic        fault;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [15:0] tb_acc[4];
  int          busy_len = 4;
  bit          busy_en = 1'b1;
  int          busy_cnt = 0;
  int          sends = 0;
  int          cyc = 0;
  int          last_send_cyc = -1;
  bit          chk_period = 1'b0;

  always #5 fpga_clock = ~fpga_clock;

  dac_wave_sequencer #(
    .NUM_CHANNELS(NCH),
    .ACC_WIDTH   (AW),
    .INTERVAL    (IV),
    .ACK_TIMEOUT (AT)
  ) dut (
    .fpga_clock  (fpga_clock),
    .rst         (rst),
    .channel_en  (channel_en),
    .step        (step),
    .mode        (mode),
    .clear_status(clear_status),
    .spi_busy    (spi_busy),
    .send        (send),
    .dac_data    (dac_data),
    .frame_active(frame_active),
    .overrun     (overrun),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sample(input logic [15:0] a, input logic [1:0] m,
                                               input logic [15:0] s);
    case (m)
      2'b00:   return a;
      2'b01:   return a[15] ? ~{a[14:0], 1'b0} : {a[14:0], 1'b0};
      2'b10:   return a[15] ? 16'hFFFF : 16'h0000;
      default: return s;
    endcase
  endfunction

  task automatic set_ch(input int ch, input logic [15:0] s, input logic [1:0] m);
    step[ch*16 +: 16] = s;
    mode[ch*2 +: 2]   = m;
  endtask

  task automatic push_frame(input int ch);
    logic [3:0]  oh;
    logic [15:0] s;
    oh = 4'b0001 << ch;
    s  = model_sample(tb_acc[ch], mode[ch*2 +: 2], step[ch*16 +: 16]);
    exp_q.push_back({4'b0011, oh, s});
    tb_acc[ch] = tb_acc[ch] + step[ch*16 +: 16];
  endtask

  task automatic wait_empty(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge fpga_clock);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_fa(input string tag, input logic lvl, input int max);
    int n = 0;
    while (frame_active !== lvl && n < max) begin
      @(negedge fpga_clock);
      n++;
    end
    check(tag, frame_active, lvl);
  endtask

  task automatic wait_send(input string tag, input int max, output int n);
    n = 0;
    while (send !== 1'b1 && n < max) begin
      @(negedge fpga_clock);
      n++;
    end
    check(tag, send, 1'b1);
  endtask

  // Scoreboard monitor: every send pulse must match the oldest expected frame.
  initial forever begin
    @(negedge fpga_clock);
    cyc++;
    if (send === 1'b1) begin
      sends++;
      if (chk_period && last_send_cyc >= 0) check("send_period", cyc - last_send_cyc, IV);
      last_send_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_send", exp_q.size(), 1);
      end else begin
        check("dac_data", dac_data, exp_q.pop_front());
      end
    end
  end

  // SPI sender model: busy rises the cycle after send and stays high busy_len cycles.
  initial forever begin
    @(negedge fpga_clock);
    if (rst) begin
      spi_busy = 1'b0;
      busy_cnt = 0;
    end else if (send === 1'b1 && busy_en) begin
      spi_busy = 1'b1;
      busy_cnt = busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt--;
    end else begin
      spi_busy = 1'b0;
      busy_cnt = 0;
    end
  end

  initial begin
    int s0;
    int n;
    for (int i = 0; i < 4; i++) tb_acc[i] = 16'd0;
    repeat (3) @(negedge fpga_clock);
    check("rst_send", send, 0);
    check("rst_dac_data", dac_data, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;

    // Single-channel saw, runs through a full accumulator wrap.
    set_ch(0, 16'd64, 2'b00);
    channel_en = 4'b0001;
    chk_period = 1'b1;
    for (int k = 0; k < 1025; k++) push_frame(0);
    wait_empty("saw_drained", 1030 * IV);
    chk_period = 1'b0;
    wait_fa("saw_idle", 1'b0, 64);

    // Channels A, B, D in order; C must never appear.
    for (int c = 0; c < 4; c++) set_ch(c, 16'h1000, 2'b00);
    channel_en = 4'b1011;
    push_frame(0);
    push_frame(1);
    push_frame(3);
    wait_fa("multi_active", 1'b1, 2 * IV);
    s0 = sends;
    wait_fa("multi_idle", 1'b0, 2 * IV);
    check("multi_sends_in_window", sends - s0, 3);
    wait_empty("multi_drained", 8);

    // Fresh accumulators for the triangle/square/DC shapes.
    rst = 1'b1;
    @(negedge fpga_clock);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tb_acc[i] = 16'd0;
    set_ch(0, 16'h4000, 2'b01);
    channel_en = 4'b0001;
    exp_q.push_back(24'h310000);
    exp_q.push_back(24'h318000);
    exp_q.push_back(24'h31FFFF);
    exp_q.push_back(24'h317FFF);
    wait_empty("tri_drained", 6 * IV);
    wait_fa("tri_idle", 1'b0, IV);
    set_ch(0, 16'h4000, 2'b10);
    exp_q.push_back(24'h310000);
    exp_q.push_back(24'h310000);
    exp_q.push_back(24'h31FFFF);
    exp_q.push_back(24'h31FFFF);
    wait_empty("sq_drained", 6 * IV);
    wait_fa("sq_idle", 1'b0, IV);
    set_ch(1, 16'h1234, 2'b11);
    channel_en = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(24'h321234);
      tb_acc[1] = tb_acc[1] + 16'h1234;
    end
    wait_empty("dc_drained", 5 * IV);
    wait_fa("dc_idle", 1'b0, IV);

    // Long busy makes the second tick land mid-sequence.
    set_ch(0, 16'd64, 2'b00);
    channel_en = 4'b0001;
    busy_len = 40;
    check("overrun_before", overrun, 0);
    push_frame(0);
    wait_empty("ovr_drained", 2 * IV);
    wait_fa("ovr_seq_done", 1'b0, 3 * IV);
    check("overrun_set", overrun, 1);
    s0 = sends;
    repeat (4) @(negedge fpga_clock);
    check("ovr_tick_dropped", sends - s0, 0);
    check("ovr_stays_idle", frame_active, 0);
    clear_status = 1'b1;
    @(negedge fpga_clock);
    clear_status = 1'b0;
    check("overrun_cleared", overrun, 0);
    busy_len = 4;
    push_frame(0);
    wait_empty("ovr_next_drained", 2 * IV);
    wait_fa("ovr_next_idle", 1'b0, IV);

    // No ack: fault after ACK_TIMEOUT cycles, rest of the sequence skipped.
    for (int c = 0; c < 4; c++) set_ch(c, 16'h1000, 2'b00);
    channel_en = 4'b1011;
    busy_en = 1'b0;
    s0 = sends;
    push_frame(0);
    wait_send("fault_send_seen", 2 * IV, n);
    repeat (AT - 1) @(negedge fpga_clock);
    check("fault_not_early", fault, 0);
    @(negedge fpga_clock);
    check("fault_set", fault, 1);
    check("fault_back_idle", frame_active, 0);
    repeat (8) @(negedge fpga_clock);
    check("fault_next_skipped", sends - s0, 1);
    busy_en = 1'b1;
    clear_status = 1'b1;
    @(negedge fpga_clock);
    clear_status = 1'b0;
    check("fault_cleared", fault, 0);
    push_frame(0);
    push_frame(1);
    push_frame(3);
    wait_empty("fault_recover_drained", 3 * IV);
    wait_fa("fault_recover_idle", 1'b0, IV);

    // Reset while waiting for busy to fall.
    channel_en = 4'b0001;
    busy_len = 10;
    push_frame(0);
    wait_send("rst_seq_send", 2 * IV, n);
    repeat (3) @(negedge fpga_clock);
    check("rst_seq_busy", spi_busy, 1);
    check("rst_seq_active", frame_active, 1);
    rst = 1'b1;
    #1;
    check("arst_send", send, 0);
    check("arst_dac_data", dac_data, 0);
    check("arst_frame_active", frame_active, 0);
    check("arst_overrun", overrun, 0);
    check("arst_fault", fault, 0);
    @(negedge fpga_clock);
    @(negedge fpga_clock);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tb_acc[i] = 16'd0;
    push_frame(0);
    wait_send("arst_first_send", 3 * IV, n);
    check("arst_first_send_latency", n, IV + 1);
    wait_empty("arst_drained", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
